// File: rtl/countdown_timer_bcd.sv
// MM:SS countdown timer held as four BCD digits, decremented once per prescaled tick.
// Drives the display mux digits directly and flags expiry to the irrigation controller.
module countdown_timer_bcd #(
  parameter int TICK_DIVISOR    = 50_000_000,
  parameter int PRESCALER_WIDTH = 26
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] preset_3,
  input  logic [3:0] preset_2,
  input  logic [3:0] preset_1,
  input  logic [3:0] preset_0,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] digit_3,
  output logic [3:0] digit_2,
  output logic [3:0] digit_1,
  output logic [3:0] digit_0,
  output logic       running,
  output logic       expired,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam logic [PRESCALER_WIDTH-1:0] TICK_LAST = PRESCALER_WIDTH'(TICK_DIVISOR - 1);

  state_t                     state_q, state_d;
  logic [15:0]                value_q, value_d;
  logic [PRESCALER_WIDTH-1:0] presc_q, presc_d;
  logic                       done_d;
  logic                       tick;
  logic                       value_is_zero;
  logic [15:0]                preset_clamped;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max);
    return (d > max) ? max : d;
  endfunction

  // Borrow ripples d0 -> d1 -> d2 -> d3; d1 wraps to 5 because it is seconds tens.
  function automatic logic [15:0] bcd_decrement(input logic [15:0] v);
    logic [15:0] r;
    logic        borrow;
    r = v;
    if (v[3:0] == 4'd0) begin
      r[3:0] = 4'd9;
      borrow = 1'b1;
    end else begin
      r[3:0] = v[3:0] - 4'd1;
      borrow = 1'b0;
    end
    if (borrow) begin
      if (v[7:4] == 4'd0) begin
        r[7:4] = 4'd5;
      end else begin
        r[7:4] = v[7:4] - 4'd1;
        borrow = 1'b0;
      end
    end
    if (borrow) begin
      if (v[11:8] == 4'd0) begin
        r[11:8] = 4'd9;
      end else begin
        r[11:8] = v[11:8] - 4'd1;
        borrow = 1'b0;
      end
    end
    if (borrow) begin
      r[15:12] = v[15:12] - 4'd1;
    end
    return r;
  endfunction

  assign preset_clamped = {clamp_digit(preset_3, 4'd9), clamp_digit(preset_2, 4'd9),
                           clamp_digit(preset_1, 4'd5), clamp_digit(preset_0, 4'd9)};
  assign value_is_zero  = (value_q == 16'h0000);
  assign tick           = (state_q == RUNNING) && (presc_q == TICK_LAST);

  always_comb begin
    state_d = state_q;
    value_d = value_q;
    presc_d = presc_q;
    done_d  = 1'b0;
    if (load) begin
      value_d = preset_clamped;
      presc_d = '0;
      state_d = IDLE;
    end else if (pause) begin
      // A tick coinciding with pause is dropped; the prescaler stays at TICK_LAST
      // so it fires on the first cycle after resume.
      if (state_q == RUNNING) begin
        state_d = PAUSED;
      end
    end else if (start && (state_q == IDLE || state_q == PAUSED) && !value_is_zero) begin
      state_d = RUNNING;
      if (state_q == IDLE) begin
        presc_d = '0;
      end
    end else if (state_q == RUNNING) begin
      if (tick) begin
        presc_d = '0;
        value_d = bcd_decrement(value_q);
        if (value_d == 16'h0000) begin
          state_d = EXPIRED;
          done_d  = 1'b1;
        end
      end else begin
        presc_d = presc_q + PRESCALER_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      value_q <= '0;
      presc_q <= '0;
      running <= 1'b0;
      expired <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      presc_q <= presc_d;
      running <= (state_d == RUNNING);
      expired <= (state_d == EXPIRED);
      done    <= done_d;
    end
  end

  assign digit_3 = value_q[15:12];
  assign digit_2 = value_q[11:8];
  assign digit_1 = value_q[7:4];
  assign digit_0 = value_q[3:0];

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Self-checking bench for countdown_timer_bcd: directed scenarios plus a randomized
// command stream, all compared against a seconds-based reference model.
module tb_countdown_timer_bcd;

  localparam int DIV = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       load = 1'b0, start = 1'b0, pause = 1'b0;
  logic [3:0] preset_3 = '0, preset_2 = '0, preset_1 = '0, preset_0 = '0;
  logic [3:0] digit_3, digit_2, digit_1, digit_0;
  logic       running, expired, done;
  logic [18:0] obs;

  int errors = 0;
  int checks = 0;

  countdown_timer_bcd #(.TICK_DIVISOR(DIV), .PRESCALER_WIDTH(4)) dut (
    .clock(clock), .reset(reset), .load(load),
    .preset_3(preset_3), .preset_2(preset_2), .preset_1(preset_1), .preset_0(preset_0),
    .start(start), .pause(pause),
    .digit_3(digit_3), .digit_2(digit_2), .digit_1(digit_1), .digit_0(digit_0),
    .running(running), .expired(expired), .done(done)
  );

  always #5 clock = ~clock;

  assign obs = {digit_3, digit_2, digit_1, digit_0, running, expired, done};

  // Reference model: remaining time as a plain count of seconds.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;
  typedef struct {
    int secs;
    int mode;
    int cycles_in_second;
    bit done;
  } model_t;
  model_t m;

  function automatic int clampi(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic model_t model_next(input model_t cur, input bit ld, input int a3, input int a2,
                                        input int a1, input int a0, input bit st, input bit ps);
    model_t n;
    n = cur;
    n.done = 1'b0;
    if (ld) begin
      n.secs = (clampi(a3, 9) * 10 + clampi(a2, 9)) * 60 + clampi(a1, 5) * 10 + clampi(a0, 9);
      n.mode = M_IDLE;
      n.cycles_in_second = 0;
    end else if (ps) begin
      if (cur.mode == M_RUN) n.mode = M_PAUSE;
    end else if (st && (cur.mode == M_IDLE || cur.mode == M_PAUSE) && cur.secs != 0) begin
      if (cur.mode == M_IDLE) n.cycles_in_second = 0;
      n.mode = M_RUN;
    end else if (cur.mode == M_RUN) begin
      if (cur.cycles_in_second == DIV - 1) begin
        n.cycles_in_second = 0;
        n.secs = cur.secs - 1;
        if (n.secs == 0) begin
          n.mode = M_EXP;
          n.done = 1'b1;
        end
      end else begin
        n.cycles_in_second = cur.cycles_in_second + 1;
      end
    end
    return n;
  endfunction

  function automatic logic [18:0] expect_vec(input model_t s);
    int mins, sec;
    mins = s.secs / 60;
    sec  = s.secs % 60;
    return {4'(mins / 10), 4'(mins % 10), 4'(sec / 10), 4'(sec % 10),
            s.mode == M_RUN, s.mode == M_EXP, s.done};
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) m <= '{secs: 0, mode: M_IDLE, cycles_in_second: 0, done: 1'b0};
    else m <= model_next(m, load, int'(preset_3), int'(preset_2), int'(preset_1),
                         int'(preset_0), start, pause);
  end

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic do_load(input logic [3:0] a3, a2, a1, a0);
    load = 1'b1; preset_3 = a3; preset_2 = a2; preset_1 = a1; preset_0 = a0;
    cyc();
    load = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    checks++;
    if (obs !== 19'h0) begin
      errors++; $display("FAIL reset_state: got %h expected %h", obs, 19'h0);
    end
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_basic_countdown();
    do_load(4'd0, 4'd0, 4'd0, 4'd3);
    pulse_start();
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (obs !== expect_vec(m)) begin
        errors++; $display("FAIL basic_model k=%0d: got %h expected %h", k, obs, expect_vec(m));
      end
      if (k == 4 || k == 8 || k == 12 || k == 13) begin
        logic [18:0] req;
        case (k)
          4:  req = {16'h0002, 3'b100};
          8:  req = {16'h0001, 3'b100};
          12: req = {16'h0000, 3'b011};
          default: req = {16'h0000, 3'b010};
        endcase
        checks++;
        if (obs !== req) begin
          errors++; $display("FAIL basic_directed k=%0d: got %h expected %h", k, obs, req);
        end
      end
      cyc();
    end
  endtask

  task automatic test_full_borrow();
    do_load(4'd1, 4'd0, 4'd0, 4'd0);
    pulse_start();
    repeat (4) cyc();
    checks++;
    if (obs !== {16'h0959, 3'b100}) begin
      errors++; $display("FAIL full_borrow: got %h expected %h", obs, {16'h0959, 3'b100});
    end
  endtask

  task automatic test_pause_resume();
    do_load(4'd0, 4'd1, 4'd0, 4'd0);
    pulse_start();
    cyc();
    cyc();
    pause = 1'b1;
    cyc();
    pause = 1'b0;
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (obs !== {16'h0100, 3'b000} || obs !== expect_vec(m)) begin
        errors++; $display("FAIL paused_hold k=%0d: got %h expected %h", k, obs, {16'h0100, 3'b000});
      end
      cyc();
    end
    pulse_start();
    cyc();
    checks++;
    if (obs !== {16'h0100, 3'b100}) begin
      errors++; $display("FAIL resume_one: got %h expected %h", obs, {16'h0100, 3'b100});
    end
    cyc();
    checks++;
    if (obs !== {16'h0059, 3'b100} || obs !== expect_vec(m)) begin
      errors++; $display("FAIL resume_two: got %h expected %h", obs, {16'h0059, 3'b100});
    end
  endtask

  task automatic test_clamp_and_zero_start();
    do_load(4'hF, 4'hA, 4'h7, 4'hC);
    checks++;
    if (obs !== {16'h9959, 3'b000}) begin
      errors++; $display("FAIL clamp: got %h expected %h", obs, {16'h9959, 3'b000});
    end
    do_load(4'd0, 4'd0, 4'd0, 4'd0);
    pulse_start();
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (obs !== 19'h0 || obs !== expect_vec(m)) begin
        errors++; $display("FAIL zero_start k=%0d: got %h expected %h", k, obs, 19'h0);
      end
      cyc();
    end
  endtask

  task automatic test_load_on_tick();
    do_load(4'd0, 4'd0, 4'd0, 4'd5);
    pulse_start();
    repeat (3) cyc();
    do_load(4'd0, 4'd2, 4'd3, 4'd0);
    checks++;
    if (obs !== {16'h0230, 3'b000} || obs !== expect_vec(m)) begin
      errors++; $display("FAIL load_on_tick: got %h expected %h", obs, {16'h0230, 3'b000});
    end
  endtask

  task automatic test_pause_on_final_tick();
    do_load(4'd0, 4'd0, 4'd0, 4'd1);
    pulse_start();
    repeat (3) cyc();
    pause = 1'b1;
    cyc();
    pause = 1'b0;
    checks++;
    if (obs !== {16'h0001, 3'b000}) begin
      errors++; $display("FAIL pause_on_tick: got %h expected %h", obs, {16'h0001, 3'b000});
    end
    pulse_start();
    cyc();
    checks++;
    if (obs !== {16'h0000, 3'b011} || obs !== expect_vec(m)) begin
      errors++; $display("FAIL resume_tick_first: got %h expected %h", obs, {16'h0000, 3'b011});
    end
  endtask

  task automatic test_async_reset_midcount();
    do_load(4'd0, 4'd0, 4'd0, 4'd9);
    pulse_start();
    repeat (6) cyc();
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== 19'h0) begin
      errors++; $display("FAIL async_reset: got %h expected %h", obs, 19'h0);
    end
    repeat (2) begin
      cyc();
      checks++;
      if (obs !== 19'h0) begin
        errors++; $display("FAIL reset_hold: got %h expected %h", obs, 19'h0);
      end
    end
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_random();
    for (int k = 0; k < 800; k++) begin
      checks++;
      if (obs !== expect_vec(m)) begin
        errors++; $display("FAIL random k=%0d: got %h expected %h", k, obs, expect_vec(m));
      end
      load  = ($urandom_range(0, 99) < 4);
      start = ($urandom_range(0, 99) < 20);
      pause = ($urandom_range(0, 99) < 8);
      preset_3 = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'd0;
      preset_2 = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
      preset_1 = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
      preset_0 = 4'($urandom);
      cyc();
    end
    load = 1'b0; start = 1'b0; pause = 1'b0;
  endtask

  initial begin
    cyc();
    test_reset();
    test_basic_countdown();
    test_full_borrow();
    test_pause_resume();
    test_clamp_and_zero_start();
    test_load_on_tick();
    test_pause_on_final_tick();
    test_async_reset_midcount();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
